// File: rtl/ring_sequence_monitor.sv
`default_nettype none
// ============================================================================
// Module   : ring_sequence_monitor
// Purpose  : Checks a 4-bit one-hot ring counter for legal transitions,
//            counts laps and records faults.
// Revision : 1.0 - initial release
// ============================================================================
module ring_sequence_monitor #(
    parameter int NBITS_COUNT = 4,
    parameter int NBITS_LAPS  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   load_seen,
    input  logic [NBITS_COUNT-1:0] Count_in,
    output logic [1:0]             Index,
    output logic                   Valid,
    output logic [NBITS_LAPS-1:0]  Laps,
    output logic                   Lap_done,
    output logic                   Error,
    output logic [3:0]             Err_count,
    output logic [1:0]             State
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    localparam logic [NBITS_COUNT-1:0] c_lap_end = NBITS_COUNT'(1) << (NBITS_COUNT - 1);
    localparam logic [NBITS_COUNT-1:0] c_lap_beg = NBITS_COUNT'(1);
    localparam logic [3:0]             c_err_max = 4'd15;

    state_t                  r_state;
    logic [NBITS_COUNT-1:0]  r_prev;
    logic                    r_load_q;
    logic [1:0]              r_index;
    logic                    r_valid;
    logic [NBITS_LAPS-1:0]   r_laps;
    logic                    r_lap_done;
    logic                    r_error;
    logic [3:0]              r_err_count;

    logic                    w_onehot;
    logic [1:0]              w_enc;
    logic [NBITS_COUNT-1:0]  w_expected;

    assign w_onehot   = (Count_in != '0) && ((Count_in & (Count_in - NBITS_COUNT'(1))) == '0);
    assign w_expected = {r_prev[NBITS_COUNT-2:0], r_prev[NBITS_COUNT-1]};

    always_comb begin
        w_enc = 2'd0;
        for (int i = 0; i < NBITS_COUNT; i++) begin
            if (Count_in[i]) begin
                w_enc = i[1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_state     <= S_IDLE;
            r_prev      <= '0;
            r_load_q    <= 1'b0;
            r_index     <= 2'd0;
            r_valid     <= 1'b0;
            r_laps      <= '0;
            r_lap_done  <= 1'b0;
            r_error     <= 1'b0;
            r_err_count <= 4'd0;
        end else begin
            r_load_q   <= load_seen;
            r_lap_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_onehot) begin
                        r_prev  <= Count_in;
                        r_index <= w_enc;
                        r_valid <= 1'b1;
                        r_state <= S_TRACK;
                    end else begin
                        r_valid <= 1'b0;
                    end
                end
                S_TRACK: begin
                    // A loaded value bypasses the successor check and never completes a lap.
                    if (r_load_q && w_onehot) begin
                        r_prev  <= Count_in;
                        r_index <= w_enc;
                        r_valid <= 1'b1;
                    end else if (Count_in == w_expected) begin
                        r_prev  <= Count_in;
                        r_index <= w_enc;
                        r_valid <= 1'b1;
                        if (r_prev == c_lap_end && Count_in == c_lap_beg) begin
                            r_laps     <= r_laps + NBITS_LAPS'(1);
                            r_lap_done <= 1'b1;
                        end
                    end else begin
                        r_valid <= 1'b0;
                        r_error <= 1'b1;
                        r_state <= S_FAULT;
                        if (r_err_count != c_err_max) begin
                            r_err_count <= r_err_count + 4'd1;
                        end
                    end
                end
                S_FAULT: begin
                    // Resync sample is trusted as-is; it is not checked and never counts a lap.
                    if (w_onehot) begin
                        r_prev  <= Count_in;
                        r_index <= w_enc;
                        r_valid <= 1'b1;
                        r_state <= S_TRACK;
                    end else begin
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign Index     = r_index;
    assign Valid     = r_valid;
    assign Laps      = r_laps;
    assign Lap_done  = r_lap_done;
    assign Error     = r_error;
    assign Err_count = r_err_count;
    assign State     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ring_sequence_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_ring_sequence_monitor
// Purpose  : Directed self-checking bench for ring_sequence_monitor; a second
//            instance with a 2-bit lap counter exercises wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ring_sequence_monitor;

    logic       r_clk = 1'b0;
    logic       r_reset, r_clear, r_load;
    logic [3:0] r_count;

    logic [1:0] w_index_a, w_index_b, w_state_a, w_state_b, w_laps_b;
    logic       w_valid_a, w_valid_b, w_done_a, w_done_b, w_err_a, w_err_b;
    logic [7:0] w_laps_a;
    logic [3:0] w_errc_a, w_errc_b;

    int n_chk  = 0;
    int n_pass = 0;
    int pulses = 0;

    always #5 r_clk = ~r_clk;

    ring_sequence_monitor #(.NBITS_COUNT(4), .NBITS_LAPS(8)) u_dut_a (
        .clk(r_clk), .reset(r_reset), .clear(r_clear), .load_seen(r_load),
        .Count_in(r_count), .Index(w_index_a), .Valid(w_valid_a), .Laps(w_laps_a),
        .Lap_done(w_done_a), .Error(w_err_a), .Err_count(w_errc_a), .State(w_state_a)
    );

    ring_sequence_monitor #(.NBITS_COUNT(4), .NBITS_LAPS(2)) u_dut_b (
        .clk(r_clk), .reset(r_reset), .clear(r_clear), .load_seen(r_load),
        .Count_in(r_count), .Index(w_index_b), .Valid(w_valid_b), .Laps(w_laps_b),
        .Lap_done(w_done_b), .Error(w_err_b), .Err_count(w_errc_b), .State(w_state_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    endtask

    task automatic step(input logic [3:0] cnt, input logic ld = 1'b0,
                        input logic rst = 1'b0, input logic clr = 1'b0);
        r_count = cnt;
        r_load  = ld;
        r_reset = rst;
        r_clear = clr;
        @(posedge r_clk);
        #1;
        if (w_done_b) pulses++;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, " index"},    w_index_a, 0);
        check_eq({tag, " valid"},    w_valid_a, 0);
        check_eq({tag, " laps"},     w_laps_a,  0);
        check_eq({tag, " lap_done"}, w_done_a,  0);
        check_eq({tag, " error"},    w_err_a,   0);
        check_eq({tag, " errcnt"},   w_errc_a,  0);
        check_eq({tag, " state"},    w_state_a, 0);
    endtask

    initial begin
        r_reset = 1'b1; r_clear = 1'b0; r_load = 1'b0; r_count = 4'd0;
        step(4'd0, 1'b0, 1'b1, 1'b0);
        step(4'd0, 1'b0, 1'b1, 1'b0);
        check_reset_vals("reset");

        step(4'd0);
        check_eq("idle zero state", w_state_a, 0);
        check_eq("idle zero error", w_err_a, 0);
        check_eq("idle zero valid", w_valid_a, 0);

        // Lap count
        step(4'd1);
        check_eq("lap s1 state", w_state_a, 1);
        check_eq("lap s1 index", w_index_a, 0);
        check_eq("lap s1 valid", w_valid_a, 1);
        step(4'd2); check_eq("lap s2 index", w_index_a, 1);
        step(4'd4); check_eq("lap s4 index", w_index_a, 2);
        step(4'd8);
        check_eq("lap s8 index", w_index_a, 3);
        check_eq("lap s8 done", w_done_a, 0);
        step(4'd1);
        check_eq("lap s1b index", w_index_a, 0);
        check_eq("lap s1b done", w_done_a, 1);
        check_eq("lap s1b laps", w_laps_a, 1);
        check_eq("lap s1b error", w_err_a, 0);

        // Load exemption: load observed while sampling 2, then 8 is exempt
        step(4'd2, 1'b1);
        check_eq("ld pre done", w_done_a, 0);
        step(4'd8);
        check_eq("ld exempt state", w_state_a, 1);
        check_eq("ld exempt index", w_index_a, 3);
        check_eq("ld exempt valid", w_valid_a, 1);
        check_eq("ld exempt error", w_err_a, 0);
        check_eq("ld exempt done", w_done_a, 0);
        step(4'd1);
        check_eq("ld after laps", w_laps_a, 2);
        check_eq("ld after done", w_done_a, 1);
        step(4'd2); step(4'd4); step(4'd8, 1'b1);
        step(4'd1);
        check_eq("ld 8to1 index", w_index_a, 0);
        check_eq("ld 8to1 laps", w_laps_a, 2);
        check_eq("ld 8to1 done", w_done_a, 0);
        check_eq("ld 8to1 valid", w_valid_a, 1);

        // Skip fault and resync
        step(4'd4);
        check_eq("skip state", w_state_a, 2);
        check_eq("skip valid", w_valid_a, 0);
        check_eq("skip error", w_err_a, 1);
        check_eq("skip errcnt", w_errc_a, 1);
        check_eq("skip index hold", w_index_a, 0);
        step(4'd8);
        check_eq("resync state", w_state_a, 1);
        check_eq("resync index", w_index_a, 3);
        check_eq("resync laps", w_laps_a, 2);
        step(4'd1);
        check_eq("post resync laps", w_laps_a, 3);
        check_eq("post resync error", w_err_a, 1);

        // Clear mid-run; the clearing edge does not evaluate Count_in
        step(4'd2, 1'b0, 1'b0, 1'b1);
        check_reset_vals("clear");
        step(4'd2);
        check_eq("clr next index", w_index_a, 1);
        check_eq("clr next valid", w_valid_a, 1);
        check_eq("clr next state", w_state_a, 1);

        // Illegal hold then resync
        step(4'd6);
        check_eq("hold state", w_state_a, 2);
        check_eq("hold errcnt", w_errc_a, 1);
        check_eq("hold index", w_index_a, 1);
        step(4'd6); step(4'd6);
        check_eq("hold3 errcnt", w_errc_a, 1);
        check_eq("hold3 state", w_state_a, 2);
        step(4'd4);
        check_eq("hold resync state", w_state_a, 1);
        check_eq("hold resync index", w_index_a, 2);
        step(4'd8);
        step(4'd8);
        check_eq("stuck state", w_state_a, 2);
        check_eq("stuck errcnt", w_errc_a, 2);
        step(4'd1);
        check_eq("resync 8to1 state", w_state_a, 1);
        check_eq("resync 8to1 laps", w_laps_a, 0);
        check_eq("resync 8to1 done", w_done_a, 0);

        // Reset and clear together, load during reset ignored
        step(4'd4, 1'b1, 1'b1, 1'b1);
        check_reset_vals("rst+clr");
        step(4'd2);
        check_eq("rc next index", w_index_a, 1);
        step(4'd1);
        check_eq("rc no exempt state", w_state_a, 2);
        check_eq("rc no exempt errcnt", w_errc_a, 1);

        // Saturation
        for (int i = 0; i < 20; i++) begin
            step(4'd1);
            step(4'd4);
            if (i == 9) check_eq("sat mid errcnt", w_errc_a, 11);
        end
        check_eq("sat errcnt", w_errc_a, 15);
        check_eq("sat state", w_state_a, 2);

        // Lap wrap on the 2-bit instance
        step(4'd0, 1'b0, 1'b1, 1'b0);
        pulses = 0;
        step(4'd1);
        for (int l = 0; l < 4; l++) begin
            step(4'd2); step(4'd4); step(4'd8); step(4'd1);
            if (l == 2) check_eq("wrap b laps3", w_laps_b, 3);
        end
        check_eq("wrap b laps", w_laps_b, 0);
        check_eq("wrap b pulses", pulses, 4);
        check_eq("wrap a laps", w_laps_a, 4);
        check_eq("wrap b error", w_err_b, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
